ysyx_25030093_lsu: RTL
======================

YSYX_25030093_LSU -- requirements
Module: ysyx_25030093_LSU

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clock and reset.
REQ-002 Parameter DATA_WIDTH, default 32, datapath width; only 32 is supported.
REQ-003 Parameter ADDR_WIDTH, default 5, register-file address width.
REQ-004 Ports (name, direction, width, meaning) SHALL be:
  clock  in  1  rising-edge clock
  reset  in  1  asynchronous, active-high reset
  in_valid  in  1  EXU result valid
  in_ready  out  1  LSU can accept a result
  in_alu_result  in  32  ALU result or effective address
  in_store_data  in  32  rs2 value for stores
  in_rd  in  ADDR_WIDTH  destination register
  in_wen  in  1  instruction writes rd
  in_mem_ren  in  1  load
  in_mem_wen  in  1  store
  in_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
  mem_req_valid  out  1  memory request valid
  mem_req_ready  in  1  memory accepts request
  mem_req_addr  out  32  word-aligned address
  mem_req_we  out  1  1 = write
  mem_req_wdata  out  32  lane-shifted store data
  mem_req_wstrb  out  4  byte strobes
  mem_resp_valid  in  1  response valid
  mem_resp_rdata  in  32  read word
  mem_resp_err  in  1  bus error
  out_valid  out  1  to register file in_valid
  out_wdata  out  32  to register file wdata
  out_waddr  out  ADDR_WIDTH  to register file waddr
  out_wen  out  1  to register file wen
  lsu_err  out  1  one-cycle fault pulse (misalign or bus error)

Function
REQ-005 The FSM SHALL have states IDLE, REQ, WAIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-006 In IDLE, on in_valid&in_ready, the block SHALL capture all in_* fields into internal registers.
REQ-007 Capture with neither ren nor wen SHALL go to DONE with out_wdata=in_alu_result and out_wen=in_wen.
REQ-008 A memory op SHALL be misaligned if (h/hu and addr[0]) or (w and addr[1:0]!=0); a misaligned op SHALL go to DONE with out_wen=0, assert lsu_err in the DONE cycle, and issue no request.
REQ-009 An aligned memory op SHALL go to REQ; in REQ, mem_req_valid=1 and addr/we/wdata/wstrb SHALL hold stable until mem_req_ready=1, then go to WAIT.
REQ-010 mem_req_addr SHALL be {addr[31:2],2'b00}; wstrb SHALL be 0001<<addr[1:0] for b, 0011<<addr[1:0] for h, and 1111 for w; wdata SHALL be store data shifted left by 8*addr[1:0]; wstrb SHALL be 0 for loads.
REQ-011 In WAIT, mem_resp_valid SHALL be sampled; a response in the REQ-accept cycle SHALL be ignored; on response go to DONE.
REQ-012 Load data SHALL be rdata>>8*addr[1:0], then sign-extended (b/h) or zero-extended (bu/hu) to 32 bits; w SHALL pass through.
REQ-013 Stores SHALL produce out_wen=0; in_rd==0 SHALL force out_wen=0.
REQ-014 mem_resp_err=1 SHALL force out_wen=0 and assert lsu_err in the DONE cycle.
REQ-015 In DONE, out_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; out_* SHALL be held registered values.
REQ-016 Latency: a non-memory op captured at cycle N SHALL give out_valid at N+1; a load with ready at N+1 and response at N+2 SHALL give out_valid at N+3.
REQ-017 out_valid, lsu_err, and mem_req_valid SHALL be 0 outside DONE/DONE/REQ respectively.

Reset
REQ-018 reset=1 SHALL asynchronously force IDLE and clear all output registers to 0; in_ready SHALL read 1 during reset.
REQ-019 Reset asserted in REQ or WAIT SHALL abandon the transaction; a late mem_resp_valid after reset SHALL be ignored in IDLE.

Verification
REQ-020 ALU op: alu_result=0x1234, rd=5, wen=1 -> next cycle out_valid=1, wdata=0x1234, waddr=5, wen=1.
REQ-021 lb from addr 0x80000003, rdata=0x80FFFFFF -> req addr 0x80000000, wstrb=0, out_wdata=0xFFFFFF80.
REQ-022 sh with addr 0x80000002, data 0xABCD -> wdata=0xABCD0000, wstrb=1100, out_wen=0.
REQ-023 lw from addr 0x80000001 -> no mem_req_valid, lsu_err=1 and out_valid=1 with out_wen=0.
REQ-024 mem_req_ready held 0 for 3 cycles -> request fields stable, in_ready=0 throughout.
REQ-025 Reset pulsed in WAIT, then mem_resp_valid=1 -> state IDLE, out_valid stays 0.

Source files
------------

// File: rtl/ysyx_25030093_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_25030093_lsu -- load/store unit between the EXU and the register file.
//
// Purpose: accepts one EXU result at a time, performs at most one memory
// access for it (byte/half/word, with lane alignment, sign/zero extension)
// and presents a single-cycle write-back beat to the register file.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   in_*                    EXU result handshake and fields
//   mem_req_*               memory request channel (word-aligned address)
//   mem_resp_*              memory response (data + bus error)
//   out_*                   register-file write-back beat
//   lsu_err                 one-cycle fault pulse (misalign or bus error)
//   dbg_state               current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. While valid is 1 and ready is 0 the sender keeps valid and all
// payload fields stable. in_ready is 1 only in IDLE; mem_req_valid is 1 only
// in REQ with address/we/wdata/wstrb driven from captured registers, so the
// payload cannot move until mem_req_ready is seen. The response side has no
// ready: mem_resp_valid is only looked at in WAIT.
// ---------------------------------------------------------------------------
module ysyx_25030093_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_store_data,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_mem_ren,
  input  logic                  in_mem_wen,
  input  logic [2:0]            in_funct3,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_we,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [3:0]            mem_req_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  input  logic                  mem_resp_err,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic [ADDR_WIDTH-1:0] out_waddr,
  output logic                  out_wen,
  output logic                  lsu_err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  ren_q, ren_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  regwen_q, regwen_d;   // instruction writes a non-zero rd
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic                  err_q, err_d;

  logic                  in_misalign;
  logic [DATA_WIDTH-1:0] ld_shifted;
  logic [DATA_WIDTH-1:0] ld_ext;

  // funct3[1:0] encodes the access size for both signed and unsigned loads.
  assign in_misalign = ((in_funct3[1:0] == 2'b01) && in_alu_result[0]) ||
                       ((in_funct3 == 3'b010) && (in_alu_result[1:0] != 2'b00));

  assign ld_shifted = mem_resp_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_ext = ld_shifted;
    case (funct3_q)
      3'b000:  ld_ext = {{(DATA_WIDTH-8){ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_ext = {{(DATA_WIDTH-16){ld_shifted[15]}}, ld_shifted[15:0]};
      3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_shifted[7:0]};
      3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_shifted[15:0]};
      default: ld_ext = ld_shifted;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    rd_d     = rd_q;
    ren_d    = ren_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    regwen_d = regwen_q;
    wdata_d  = wdata_q;
    wen_d    = wen_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d   = in_alu_result;
          sdata_d  = in_store_data;
          rd_d     = in_rd;
          ren_d    = in_mem_ren;
          we_d     = in_mem_wen;
          funct3_d = in_funct3;
          regwen_d = in_wen && (in_rd != '0);
          if (!in_mem_ren && !in_mem_wen) begin
            wdata_d = in_alu_result;
            wen_d   = in_wen && (in_rd != '0);
            err_d   = 1'b0;
            state_d = S_DONE;
          end else if (in_misalign) begin
            // Faulting access: never reaches the bus, only reports the error.
            wdata_d = '0;
            wen_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          wdata_d = ren_q ? ld_ext : '0;
          wen_d   = ren_q && regwen_q && !mem_resp_err;
          err_d   = mem_resp_err;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      sdata_q  <= '0;
      rd_q     <= '0;
      ren_q    <= 1'b0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      regwen_q <= 1'b0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      rd_q     <= rd_d;
      ren_q    <= ren_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      regwen_q <= regwen_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      err_q    <= err_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem_req_we    = we_q;
  assign mem_req_wdata = sdata_q << {addr_q[1:0], 3'b000};

  always_comb begin
    mem_req_wstrb = 4'b0000;
    if (we_q) begin
      case (funct3_q[1:0])
        2'b00:   mem_req_wstrb = 4'b0001 << addr_q[1:0];
        2'b01:   mem_req_wstrb = 4'b0011 << addr_q[1:0];
        default: mem_req_wstrb = 4'b1111;
      endcase
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign out_wdata = wdata_q;
  assign out_waddr = rd_q;
  assign out_wen   = wen_q;
  assign lsu_err   = (state_q == S_DONE) && err_q;
  assign dbg_state = state_q;

endmodule
